// File: rtl/count_pkg.sv
// Shared types and helpers for the wrap-counter receive checker.
// Holds the checker state encoding and the successor function.
package count_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  localparam int MAX_CNT_DEF = 100;

  // Next value of a 0..max_cnt wrap counter.
  function automatic int unsigned succ(
    input int unsigned x,
    input int unsigned max_cnt
  );
    return (x == max_cnt) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Tally with synchronous clear; saturates at all-ones or wraps.
// SAT selects the behaviour at the top of the range.
module sat_counter #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic at_top;
  assign at_top = &cnt;

  // Clear beats increment; saturating mode stops at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !(SAT && at_top))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/count_checker.sv
// Locks onto a 0..MAX_CNT wrap counter and checks each sample.
// Reports wraps and sequence errors with pulses and tallies.
module count_checker
  import count_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_CNT  = MAX_CNT_DEF,
  parameter int LOCK_LEN = 4,
  parameter int WCNT_W   = 16,
  parameter int ECNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_valid,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WCNT_W-1:0] wrap_count,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ECNT_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_CNT);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_LEN);

  state_e           state, state_nx;
  logic [WIDTH-1:0] prev, prev_nx;
  logic [RUN_W-1:0] run, run_nx, run_inc;
  logic [WIDTH-1:0] cnt_q, succ_prev;
  logic             vld_q, clr_q;
  logic             match, is_zero;
  logic             wrap_nx, err_nx;

  // Input stage: gives the one-cycle response latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      cnt_q <= count_in;
      vld_q <= count_valid;
      clr_q <= clear;
    end
  end

  assign succ_prev = WIDTH'(succ(32'(prev), 32'(MAX_CNT)));
  assign match     = (cnt_q <= MAX_V) && (cnt_q == succ_prev);
  assign is_zero   = (cnt_q == '0);
  assign run_inc   = run + 1'b1;

  // Next state, tracked value, run length and event decisions.
  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    run_nx   = run;
    wrap_nx  = 1'b0;
    err_nx   = 1'b0;
    if (vld_q) begin
      unique case (state)
        UNLOCKED: begin
          if (is_zero) begin
            state_nx = ACQUIRE;
            prev_nx  = '0;
            run_nx   = '0;
          end
        end
        ACQUIRE: begin
          if (match) begin
            prev_nx = cnt_q;
            run_nx  = run_inc;
            if (run_inc == LOCK_V)
              state_nx = LOCKED;
          end else if (is_zero) begin
            prev_nx = '0;
            run_nx  = '0;
          end else begin
            state_nx = UNLOCKED;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_nx = cnt_q;
            wrap_nx = (prev == MAX_V) && is_zero;
          end else begin
            err_nx = 1'b1;
            if (is_zero) begin
              state_nx = ACQUIRE;
              prev_nx  = '0;
              run_nx   = '0;
            end else begin
              state_nx = UNLOCKED;
            end
          end
        end
        default: state_nx = UNLOCKED;
      endcase
    end
  end

  // Checker state and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= UNLOCKED;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      run        <= run_nx;
      locked     <= (state_nx == LOCKED);
      wrap_pulse <= wrap_nx;
      err_pulse  <= err_nx;
    end
  end

  // Sticky error flag; clear wins over a same-cycle error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_sticky <= 1'b0;
    else if (clr_q)
      err_sticky <= 1'b0;
    else if (err_nx)
      err_sticky <= 1'b1;
  end

  sat_counter #(.W(WCNT_W), .SAT(1'b0)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_nx),
    .clr   (clr_q),
    .cnt   (wrap_count)
  );

  sat_counter #(.W(ECNT_W), .SAT(1'b1)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_nx),
    .clr   (clr_q),
    .cnt   (err_count)
  );

endmodule

// File: tb/tb_count_checker.sv
// Directed scoreboard bench for count_checker.
// Expected outputs are queued per sample and checked two edges later.
module tb_count_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  count_in = '0;
  logic        count_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked, wrap_pulse, err_pulse, err_sticky;
  logic [15:0] wrap_count;
  logic [7:0]  err_count;

  typedef struct packed {
    logic        lk;
    logic        wp;
    logic [15:0] wc;
    logic        ep;
    logic        es;
    logic [7:0]  ec;
  } obs_t;

  obs_t q[$];
  int total = 0;
  int bad = 0;

  int ms = 0, mprev = 0, mrun = 0, mwc = 0, mec = 0, mes = 0;

  count_checker dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .clear       (clear),
    .locked      (locked),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .err_pulse   (err_pulse),
    .err_sticky  (err_sticky),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic obs_t cur();
    obs_t o;
    o.lk = locked; o.wp = wrap_pulse; o.wc = wrap_count;
    o.ep = err_pulse; o.es = err_sticky; o.ec = err_count;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t o, input obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    ms = 0; mprev = 0; mrun = 0; mwc = 0; mec = 0; mes = 0;
    q.delete();
  endtask

  task automatic step(input bit v, input int c, input bit clr);
    obs_t e;
    bit wp, ep, m;
    @(negedge clk);
    if (q.size() == 2) chk("seq", cur(), q.pop_front());
    count_valid = v; count_in = 8'(c); clear = clr;
    wp = 0; ep = 0;
    m = (c <= 100) && (c == ((mprev == 100) ? 0 : mprev + 1));
    if (v) begin
      if (ms == 0) begin
        if (c == 0) begin ms = 1; mprev = 0; mrun = 0; end
      end else if (ms == 1) begin
        if (m) begin
          mprev = c; mrun++;
          if (mrun == 4) ms = 2;
        end else if (c == 0) begin
          mprev = 0; mrun = 0;
        end else ms = 0;
      end else begin
        if (m) begin
          wp = (mprev == 100) && (c == 0);
          mprev = c;
        end else begin
          ep = 1;
          if (c == 0) begin ms = 1; mprev = 0; mrun = 0; end
          else ms = 0;
        end
      end
    end
    if (clr) begin
      mwc = 0; mec = 0; mes = 0;
    end else begin
      if (wp) mwc = (mwc + 1) % 65536;
      if (ep) begin mes = 1; if (mec < 255) mec++; end
    end
    e.lk = (ms == 2); e.wp = wp; e.wc = 16'(mwc);
    e.ep = ep; e.es = mes[0]; e.ec = 8'(mec);
    q.push_back(e);
  endtask

  task automatic run(input int a, input int b);
    for (int i = a; i <= b; i++) step(1, i, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom_range(0, 255), 0);
  endtask

  initial begin
    obs_t z;
    obs_t e;
    z = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", cur(), z);
    #1 reset = 1'b1;

    run(0, 4);
    idle(2);
    e = z; e.lk = 1'b1;
    chk("lock_after_4", cur(), e);
    run(5, 100);
    run(0, 100);
    run(0, 100);
    run(0, 50);
    idle(2);
    e.wc = 16'd3;
    chk("three_wraps", cur(), e);

    step(1, 52, 0);
    run(0, 4);
    run(5, 30);
    step(1, 0, 0);
    run(1, 4);
    run(5, 20);
    step(1, 120, 0);

    step(1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, i, 0);
      if (i % 3 == 0) idle(2);
    end
    step(1, 77, 1);
    idle(2);

    run(0, 4);
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0);
      run(1, 4);
    end
    idle(2);
    e = z; e.lk = 1'b1; e.es = 1'b1; e.ec = 8'hff;
    chk("err_saturate", cur(), e);

    run(5, 40);
    @(posedge clk);
    #2;
    reset = 1'b0;
    count_valid = 1'b0;
    clear = 1'b0;
    #1;
    chk("async_reset", cur(), z);
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    step(1, 57, 0);
    step(1, 58, 0);
    idle(3);
    chk("no_lock_57_58", cur(), z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Receive side of the free-running wrap counter interface used in the image-processing pipeline. The counter produces the sequence 0..MAX_CNT and then returns to 0.
- The block locks onto that sequence, checks that every sample is the expected successor, and emits a wrap (period) pulse and a wrap tally.
- It flags sequence errors with pulse, sticky and saturating-count outputs.
- It sits beside any consumer of the counter output, for example a line or frame timing check.

Parameters:
- WIDTH, 8, width of the incoming count.
- MAX_CNT, 100, terminal count; the sequence after MAX_CNT is 0.
- LOCK_LEN, 4, number of consecutive correct successors required to enter LOCKED (≥1).
- WCNT_W, 16, width of the wrap tally.
- ECNT_W, 8, width of the error tally.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- count_in  in  WIDTH  sample from the counter.
- count_valid  in  1  count_in is sampled only on cycles where this is 1.
- clear  in  1  synchronous clear of the tallies and the sticky flag.
- locked  out  1  1 while in state LOCKED.
- wrap_pulse  out  1  one-cycle pulse on each MAX_CNT→0 transition seen while LOCKED.
- wrap_count  out  WCNT_W  number of wraps; wraps modulo 2^WCNT_W.
- err_pulse  out  1  one-cycle pulse on each sequence error.
- err_sticky  out  1  set on error, held until clear or reset.
- err_count  out  ECNT_W  error tally; saturates at all-ones.

Behaviour:
- Reset (reset=0, asynchronous): state=UNLOCKED, prev=0, run=0, and all outputs 0.
- succ(x): 0 if x==MAX_CNT, else x+1, computed at WIDTH bits. A sample with count_in>MAX_CNT never matches succ().
- When count_valid=0, the state, prev and run hold, and both pulses are 0.
- All outputs are registered. The response to the sample accepted on edge N is visible after edge N+1, so latency is 1 cycle.
- States:
  - UNLOCKED: a valid sample ==0 sets prev=0, run=0 and moves to ACQUIRE. Any other value stays in UNLOCKED. No errors are flagged here.
  - ACQUIRE: valid sample ==succ(prev) → prev=sample, run=run+1. When run reaches LOCK_LEN, go to LOCKED. A mismatch goes to UNLOCKED with no error, except a mismatching sample ==0, which restarts ACQUIRE with run=0.
  - LOCKED: valid sample ==succ(prev) → prev=sample. If prev==MAX_CNT and sample==0, then wrap_pulse=1 and wrap_count+1. A mismatch gives err_pulse=1, err_sticky=1, err_count+1 (saturating) and goes to UNLOCKED. If that mismatching sample ==0, go directly to ACQUIRE instead, with prev=0.
- locked=1 exactly while the state is LOCKED.
- clear=1:
  - wrap_count, err_count and err_sticky go to 0.
  - The state machine is unaffected.
  - If an error or wrap occurs in the same cycle, the pulse still asserts, but clear wins for the tallies and the sticky flag (they end at 0).
- Saturation: err_count holds at all-ones. wrap_count rolls over to 0.
- Reset mid-operation aborts immediately, with no pulse emitted. After release, the block must reacquire from a 0 sample.

Decomposition:
- Shared package count_pkg holds the state enumeration (UNLOCKED, ACQUIRE, LOCKED) and a constant function for succ(). The counter and checker use the same MAX_CNT default there (100).
- One natural sub-module: sat_counter, a parameterised-width saturating/rolling tally with inc and clr inputs. It is instantiated twice: wrap mode and saturate mode.

Test Plan:
- Reset, then a clean sequence 0,1,2,3,4 (valid every cycle) → locked=1 one cycle after the sample 4 is accepted (LOCK_LEN=4). wrap_pulse=0 and err_count=0 throughout.
- Locked run through 99,100,0 → a single wrap_pulse one cycle after the 0 sample, and wrap_count=1. Over 3 full periods, wrap_count=3.
- Locked, inject 50,52 → err_pulse once, err_sticky=1, err_count=1, locked=0. Then feeding 0,1,2,3,4 relocks and err_sticky stays 1.
- Locked at 30, inject 0 → error counted, state ACQUIRE with prev=0. Then 1,2,3,4 relock with no further error.
- count_in=120 while locked → error. Gaps with count_valid=0 inside a correct sequence → no error and no state change.
- Clear asserted together with an error → err_pulse=1 but err_count=0 and err_sticky=0 after the edge. Force 255 errors plus 1 more → err_count stays 255.
- Async reset asserted mid-period → all outputs 0 without waiting for a clock edge. After release, samples 57,58 leave the block UNLOCKED.
